// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding, access-size codes
// and byte-lane width.
package mem_stage_pkg;

  localparam int BE_WIDTH = 32 / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_stage_if.sv
// Single-port data-memory bus: request/ready handshake plus rvalid read return.
interface mem_stage_if #(
  parameter int XLEN = 32
);
  import mem_stage_pkg::*;

  logic                req;
  logic                we;
  logic [XLEN-1:0]     addr;
  logic [BE_WIDTH-1:0] be;
  logic [XLEN-1:0]     wdata;
  logic                ready;
  logic                rvalid;
  logic [XLEN-1:0]     rdata;

  modport master (output req, we, addr, be, wdata, input ready, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output ready, rvalid, rdata);

endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store lane steering, load extraction/extension
// and misalignment detection. Lane logic assumes XLEN = 32.
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]          st_addr_lo,
  input  logic [2:0]          st_funct3,
  input  logic [XLEN-1:0]     st_data,
  output logic [BE_WIDTH-1:0] st_be,
  output logic [XLEN-1:0]     st_wdata,
  output logic                misaligned,
  input  logic [1:0]          ld_addr_lo,
  input  logic [2:0]          ld_funct3,
  input  logic [XLEN-1:0]     ld_rdata,
  output logic [XLEN-1:0]     ld_result
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Store-side byte enables, replicated write data and alignment check
  always_comb begin
    st_be      = 4'b1111;
    st_wdata   = st_data;
    misaligned = 1'b0;
    case (st_funct3)
      F3_B, F3_BU: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_H, F3_HU: begin
        st_be      = 4'b0011 << st_addr_lo;
        st_wdata   = {2{st_data[15:0]}};
        misaligned = st_addr_lo[0];
      end
      // undefined size codes behave as a full word
      default: begin
        st_be      = 4'b1111;
        st_wdata   = st_data;
        misaligned = (st_addr_lo != 2'b00);
      end
    endcase
  end

  // Load-side lane selection and sign/zero extension
  always_comb begin
    ld_byte_s = ld_rdata[7:0];
    case (ld_addr_lo)
      2'd0:    ld_byte_s = ld_rdata[7:0];
      2'd1:    ld_byte_s = ld_rdata[15:8];
      2'd2:    ld_byte_s = ld_rdata[23:16];
      2'd3:    ld_byte_s = ld_rdata[31:24];
      default: ld_byte_s = ld_rdata[7:0];
    endcase
    if (ld_addr_lo[1]) begin
      ld_half_s = ld_rdata[31:16];
    end else begin
      ld_half_s = ld_rdata[15:0];
    end
    case (ld_funct3)
      F3_B:    ld_result = {{(XLEN-8){ld_byte_s[7]}}, ld_byte_s};
      F3_BU:   ld_result = {{(XLEN-8){1'b0}}, ld_byte_s};
      F3_H:    ld_result = {{(XLEN-16){ld_half_s[15]}}, ld_half_s};
      F3_HU:   ld_result = {{(XLEN-16){1'b0}}, ld_half_s};
      default: ld_result = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues loads/stores on the data-memory bus, stalls EX while
// a transaction is outstanding and emits one registered write-back beat per instruction.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  input  logic [XLEN-1:0]           ex_alu_result,
  input  logic [XLEN-1:0]           ex_store_data,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic [2:0]                ex_funct3,
  output logic                      stall,
  mem_stage_if.master               dmem,
  output logic                      wb_valid,
  output logic [XLEN-1:0]           wb_result,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      wb_reg_write,
  output logic                      wb_misaligned
);

  state_t                    state_r;
  logic [REG_ADDR_WIDTH-1:0] rd_r;
  logic [2:0]                funct3_r;
  logic [1:0]                addr_lo_r;
  logic                      reg_write_r;
  logic                      is_store_r;

  logic                      mem_op_s;
  logic                      misaligned_s;
  logic [BE_WIDTH-1:0]       st_be_s;
  logic [XLEN-1:0]           st_wdata_s;
  logic [XLEN-1:0]           ld_result_s;

  assign mem_op_s = ex_mem_read | ex_mem_write;
  assign stall    = (state_r != ST_IDLE);

  mem_align #(.XLEN(XLEN)) u_align (
    .st_addr_lo (ex_alu_result[1:0]),
    .st_funct3  (ex_funct3),
    .st_data    (ex_store_data),
    .st_be      (st_be_s),
    .st_wdata   (st_wdata_s),
    .misaligned (misaligned_s),
    .ld_addr_lo (addr_lo_r),
    .ld_funct3  (funct3_r),
    .ld_rdata   (dmem.rdata),
    .ld_result  (ld_result_s)
  );

  // Stage FSM with registered bus request and write-back beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      rd_r          <= '0;
      funct3_r      <= 3'b000;
      addr_lo_r     <= 2'b00;
      reg_write_r   <= 1'b0;
      is_store_r    <= 1'b0;
      dmem.req      <= 1'b0;
      dmem.we       <= 1'b0;
      dmem.addr     <= '0;
      dmem.be       <= '0;
      dmem.wdata    <= '0;
      wb_valid      <= 1'b0;
      wb_result     <= '0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
      wb_misaligned <= 1'b0;
    end else begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_misaligned <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (ex_valid && !mem_op_s) begin
            wb_valid     <= 1'b1;
            wb_result    <= ex_alu_result;
            wb_rd        <= ex_rd;
            wb_reg_write <= ex_reg_write;
          end else if (ex_valid && misaligned_s) begin
            // faulting address goes out on the result bus for the trap handler
            wb_valid      <= 1'b1;
            wb_misaligned <= 1'b1;
            wb_result     <= ex_alu_result;
            wb_rd         <= ex_rd;
          end else if (ex_valid) begin
            rd_r        <= ex_rd;
            funct3_r    <= ex_funct3;
            addr_lo_r   <= ex_alu_result[1:0];
            reg_write_r <= ex_reg_write;
            is_store_r  <= ex_mem_write & ~ex_mem_read;
            dmem.req    <= 1'b1;
            dmem.we     <= ex_mem_write & ~ex_mem_read;
            dmem.addr   <= {ex_alu_result[XLEN-1:2], 2'b00};
            dmem.be     <= st_be_s;
            dmem.wdata  <= st_wdata_s;
            state_r     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dmem.ready) begin
            dmem.req <= 1'b0;
            dmem.we  <= 1'b0;
            if (is_store_r) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_r;
              state_r  <= ST_IDLE;
            end else begin
              state_r  <= ST_WAIT_R;
            end
          end
        end
        ST_WAIT_R: begin
          if (dmem.rvalid) begin
            wb_valid     <= 1'b1;
            wb_result    <= ld_result_s;
            wb_rd        <= rd_r;
            wb_reg_write <= reg_write_r;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          dmem.req <= 1'b0;
          dmem.we  <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed table-driven bench for mem_stage, plus back-to-back and mid-load reset sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_misaligned;

  int n_cmp;
  int n_err;

  mem_stage_if #(.XLEN(32)) dmem_bus ();

  mem_stage #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_funct3     (ex_funct3),
    .stall         (stall),
    .dmem          (dmem_bus),
    .wb_valid      (wb_valid),
    .wb_result     (wb_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_misaligned (wb_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd_op;
    logic        wr_op;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        rw;
    logic [2:0]  f3;
    int          rdy;
    int          rv;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_res;
    logic        e_rw;
    logic        e_mis;
    logic        chk_res;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic rd_op, input logic wr_op, input logic [31:0] alu,
                              input logic [31:0] sdata, input logic [4:0] rd, input logic rw,
                              input logic [2:0] f3, input int rdy, input int rv,
                              input logic [31:0] rdata, input logic [31:0] e_addr,
                              input logic [3:0] e_be, input logic [31:0] e_wdata,
                              input logic [31:0] e_res, input logic e_rw, input logic e_mis,
                              input logic chk_res);
    vec_t v;
    v.rd_op = rd_op;   v.wr_op = wr_op;     v.alu = alu;     v.sdata = sdata;
    v.rd = rd;         v.rw = rw;           v.f3 = f3;       v.rdy = rdy;
    v.rv = rv;         v.rdata = rdata;     v.e_addr = e_addr;
    v.e_be = e_be;     v.e_wdata = e_wdata; v.e_res = e_res;
    v.e_rw = e_rw;     v.e_mis = e_mis;     v.chk_res = chk_res;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Instruction that must be ignored because the stage is busy
  task automatic drive_junk();
    ex_valid      = 1'b1;
    ex_alu_result = 32'hFFFF_FFFF;
    ex_store_data = 32'h0BAD_0BAD;
    ex_rd         = 5'd30;
    ex_reg_write  = 1'b1;
    ex_mem_read   = 1'b1;
    ex_mem_write  = 1'b0;
    ex_funct3     = F3_W;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic is_mem;
    string p;
    is_mem = v.rd_op | v.wr_op;
    p = $sformatf("v%0d", idx);
    ex_valid      = 1'b1;
    ex_alu_result = v.alu;
    ex_store_data = v.sdata;
    ex_rd         = v.rd;
    ex_reg_write  = v.rw;
    ex_mem_read   = v.rd_op;
    ex_mem_write  = v.wr_op;
    ex_funct3     = v.f3;
    dmem_bus.rvalid = !is_mem;
    @(posedge clk); @(negedge clk);
    dmem_bus.rvalid = 1'b0;
    if (!is_mem || v.e_mis) begin
      ex_valid = 1'b0;
      check({p, ".req_none"}, 32'(dmem_bus.req), 32'd0);
      check({p, ".stall"}, 32'(stall), 32'd0);
    end else begin
      for (int i = 0; i <= v.rdy; i++) begin
        check({p, ".req"}, 32'(dmem_bus.req), 32'd1);
        check({p, ".we"}, 32'(dmem_bus.we), 32'(v.wr_op));
        check({p, ".addr"}, dmem_bus.addr, v.e_addr);
        check({p, ".be"}, 32'(dmem_bus.be), 32'(v.e_be));
        if (v.wr_op) check({p, ".wdata"}, dmem_bus.wdata, v.e_wdata);
        check({p, ".stall_req"}, 32'(stall), 32'd1);
        check({p, ".wbv_req"}, 32'(wb_valid), 32'd0);
        drive_junk();
        dmem_bus.ready  = (i == v.rdy);
        dmem_bus.rvalid = (i != v.rdy);
        @(posedge clk); @(negedge clk);
      end
      dmem_bus.ready  = 1'b0;
      dmem_bus.rvalid = 1'b0;
      if (!v.wr_op) begin
        for (int j = 0; j <= v.rv; j++) begin
          check({p, ".stall_wait"}, 32'(stall), 32'd1);
          check({p, ".req_wait"}, 32'(dmem_bus.req), 32'd0);
          check({p, ".wbv_wait"}, 32'(wb_valid), 32'd0);
          dmem_bus.rvalid = (j == v.rv);
          dmem_bus.rdata  = (j == v.rv) ? v.rdata : 32'h5A5A_5A5A;
          @(posedge clk); @(negedge clk);
        end
        dmem_bus.rvalid = 1'b0;
      end
      ex_valid = 1'b0;
      check({p, ".stall_done"}, 32'(stall), 32'd0);
      check({p, ".req_done"}, 32'(dmem_bus.req), 32'd0);
    end
    check({p, ".wb_valid"}, 32'(wb_valid), 32'd1);
    check({p, ".wb_reg_write"}, 32'(wb_reg_write), 32'(v.e_rw));
    check({p, ".wb_misaligned"}, 32'(wb_misaligned), 32'(v.e_mis));
    if (v.chk_res) begin
      check({p, ".wb_result"}, wb_result, v.e_res);
      check({p, ".wb_rd"}, 32'(wb_rd), 32'(v.rd));
    end
    @(posedge clk); @(negedge clk);
    check({p, ".wb_valid_once"}, 32'(wb_valid), 32'd0);
    check({p, ".stall_after"}, 32'(stall), 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    clk = 1'b0; rst_n = 1'b0;
    ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_rd = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = 3'b000;
    dmem_bus.ready = 1'b0; dmem_bus.rvalid = 1'b0; dmem_bus.rdata = '0;

    //            rd wr alu           sdata         rd    rw f3     rdy rv rdata         e_addr        e_be     e_wdata       e_res         erw emis chk
    vecs[0]  = mk(0, 0, 32'h0000_00A5, 32'h0,        5'd7,  1, F3_B,  0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_00A5, 1, 0, 1);
    vecs[1]  = mk(0, 1, 32'h0000_1003, 32'h1234_56EF, 5'd3,  1, F3_B,  3, 0, 32'h0,        32'h0000_1000, 4'b1000, 32'hEFEF_EFEF, 32'h0,        0, 0, 0);
    vecs[2]  = mk(1, 0, 32'h0000_2002, 32'h0,        5'd9,  1, F3_B,  0, 1, 32'h0080_0000, 32'h0000_2000, 4'b0100, 32'h0,        32'hFFFF_FF80, 1, 0, 1);
    vecs[3]  = mk(1, 0, 32'h0000_2002, 32'h0,        5'd10, 1, F3_BU, 0, 1, 32'h0080_0000, 32'h0000_2000, 4'b0100, 32'h0,        32'h0000_0080, 1, 0, 1);
    vecs[4]  = mk(1, 0, 32'h0000_2002, 32'h0,        5'd11, 1, F3_H,  1, 0, 32'h8001_1234, 32'h0000_2000, 4'b1100, 32'h0,        32'hFFFF_8001, 1, 0, 1);
    vecs[5]  = mk(1, 0, 32'h0000_2000, 32'h0,        5'd12, 1, F3_W,  0, 2, 32'h8001_1234, 32'h0000_2000, 4'b1111, 32'h0,        32'h8001_1234, 1, 0, 1);
    vecs[6]  = mk(1, 0, 32'h0000_3001, 32'h0,        5'd13, 1, F3_W,  0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        0, 1, 0);
    vecs[7]  = mk(0, 1, 32'h0000_4002, 32'hAAAA_BEEF, 5'd14, 0, F3_H,  2, 0, 32'h0,        32'h0000_4000, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0, 0, 0);
    vecs[8]  = mk(0, 1, 32'h0000_5004, 32'hDEAD_BEEF, 5'd15, 0, F3_W,  1, 0, 32'h0,        32'h0000_5004, 4'b1111, 32'hDEAD_BEEF, 32'h0,        0, 0, 0);
    vecs[9]  = mk(1, 0, 32'h0000_6000, 32'h0,        5'd16, 1, F3_HU, 0, 0, 32'h1234_F00D, 32'h0000_6000, 4'b0011, 32'h0,        32'h0000_F00D, 1, 0, 1);
    vecs[10] = mk(0, 1, 32'h0000_7001, 32'h5555_5555, 5'd17, 1, F3_H,  0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        0, 1, 0);
    vecs[11] = mk(1, 0, 32'h0000_8001, 32'h0,        5'd18, 0, F3_B,  0, 1, 32'h0000_7F00, 32'h0000_8000, 4'b0010, 32'h0,        32'h0000_007F, 0, 0, 1);
    vecs[12] = mk(1, 0, 32'h0000_9000, 32'h0,        5'd19, 1, 3'b011, 0, 0, 32'hCAFE_F00D, 32'h0000_9000, 4'b1111, 32'h0,       32'hCAFE_F00D, 1, 0, 1);
    vecs[13] = mk(1, 0, 32'h0000_9002, 32'h0,        5'd20, 1, 3'b111, 0, 0, 32'h0,       32'h0,        4'b0000, 32'h0,        32'h0,        0, 1, 0);
    vecs[14] = mk(0, 0, 32'hFFFF_FFFF, 32'h0,        5'd31, 0, F3_W,  0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFF_FFFF, 0, 0, 1);
    vecs[15] = mk(0, 1, 32'h0000_A000, 32'h0000_0042, 5'd21, 0, F3_B,  0, 0, 32'h0,        32'h0000_A000, 4'b0001, 32'h4242_4242, 32'h0,        0, 0, 0);
    vecs[16] = mk(1, 0, 32'h0000_B000, 32'h0,        5'd22, 1, F3_H,  0, 0, 32'h0000_7FFF, 32'h0000_B000, 4'b0011, 32'h0,        32'h0000_7FFF, 1, 0, 1);
    vecs[17] = mk(1, 0, 32'h0000_C003, 32'h0,        5'd23, 1, F3_BU, 0, 1, 32'hF100_0000, 32'h0000_C000, 4'b1000, 32'h0,        32'h0000_00F1, 1, 0, 1);

    repeat (2) @(negedge clk);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.req", 32'(dmem_bus.req), 32'd0);
    check("rst.we", 32'(dmem_bus.we), 32'd0);
    check("rst.addr", dmem_bus.addr, 32'd0);
    check("rst.be", 32'(dmem_bus.be), 32'd0);
    check("rst.wdata", dmem_bus.wdata, 32'd0);
    check("rst.wb_valid", 32'(wb_valid), 32'd0);
    check("rst.wb_result", wb_result, 32'd0);
    check("rst.wb_rd", 32'(wb_rd), 32'd0);
    check("rst.wb_reg_write", 32'(wb_reg_write), 32'd0);
    check("rst.wb_misaligned", 32'(wb_misaligned), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle.wb_valid", 32'(wb_valid), 32'd0);

    for (int k = 0; k < 18; k++) run_vec(k, vecs[k]);

    // Store followed immediately by a pass-through in the cycle stall drops
    ex_valid = 1'b1; ex_alu_result = 32'h0000_E000; ex_store_data = 32'h1122_3344;
    ex_rd = 5'd2; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b1; ex_funct3 = F3_W;
    @(posedge clk); @(negedge clk);
    check("b2b.stall_req", 32'(stall), 32'd1);
    dmem_bus.ready = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_bus.ready = 1'b0;
    check("b2b.stall_idle", 32'(stall), 32'd0);
    check("b2b.store_wbv", 32'(wb_valid), 32'd1);
    ex_valid = 1'b1; ex_alu_result = 32'h0000_0077; ex_rd = 5'd4; ex_reg_write = 1'b1;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    @(posedge clk); @(negedge clk);
    ex_valid = 1'b0;
    check("b2b.pass_wbv", 32'(wb_valid), 32'd1);
    check("b2b.pass_result", wb_result, 32'h0000_0077);
    check("b2b.pass_rd", 32'(wb_rd), 32'd4);
    check("b2b.pass_rw", 32'(wb_reg_write), 32'd1);
    @(posedge clk); @(negedge clk);

    // Reset while a load waits for its data
    ex_valid = 1'b1; ex_alu_result = 32'h0000_D000; ex_rd = 5'd6; ex_reg_write = 1'b1;
    ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = F3_W;
    @(posedge clk); @(negedge clk);
    ex_valid = 1'b0;
    dmem_bus.ready = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_bus.ready = 1'b0;
    check("rstw.stall_wait", 32'(stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstw.stall", 32'(stall), 32'd0);
    check("rstw.req", 32'(dmem_bus.req), 32'd0);
    check("rstw.wb_valid", 32'(wb_valid), 32'd0);
    check("rstw.addr", dmem_bus.addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ex_valid = 1'b1; ex_alu_result = 32'h0000_0123; ex_rd = 5'd8; ex_reg_write = 1'b1;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    @(posedge clk); @(negedge clk);
    ex_valid = 1'b0;
    check("rstw.pass_wbv", 32'(wb_valid), 32'd1);
    check("rstw.pass_result", wb_result, 32'h0000_0123);
    check("rstw.pass_rd", 32'(wb_rd), 32'd8);
    check("rstw.pass_stall", 32'(stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Pipeline MEM stage, directly downstream of the EX-stage ALU. It consumes the ALU result as a load/store address, or as a pass-through value, and drives a single-port data-memory request/ready/rvalid handshake. It aligns store data to byte lanes, sign/zero-extends load data, and presents a registered one-cycle write-back beat to WB. It stalls upstream while a memory transaction is outstanding.

Parameters:
XLEN, 32, datapath width; byte-lane logic is defined for 32 only.
REG_ADDR_WIDTH, 5, destination register index width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
ex_valid  in  1  EX presents an instruction this cycle.
ex_alu_result  in  XLEN  ALU result; address for loads/stores.
ex_store_data  in  XLEN  rs2 value for stores.
ex_rd  in  REG_ADDR_WIDTH  destination register.
ex_reg_write  in  1  instruction writes rd.
ex_mem_read  in  1  load.
ex_mem_write  in  1  store; mutually exclusive with ex_mem_read.
ex_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
stall  out  1  stage busy; EX must hold its outputs.
dmem_req  out  1  memory request.
dmem_we  out  1  1 = write.
dmem_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00}).
dmem_be  out  4  byte enables.
dmem_wdata  out  XLEN  lane-replicated store data.
dmem_ready  in  1  request accepted when dmem_req & dmem_ready.
dmem_rvalid  in  1  read data valid.
dmem_rdata  in  XLEN  read word.
wb_valid  out  1  one-cycle write-back beat.
wb_result  out  XLEN  value for rd.
wb_rd  out  REG_ADDR_WIDTH  destination register.
wb_reg_write  out  1  qualified write enable.
wb_misaligned  out  1  beat carries a misaligned-access exception.

Behaviour:
- Reset (async, rst_n=0): state IDLE. wb_valid, wb_reg_write, wb_misaligned, dmem_req and dmem_we are 0; wb_result, wb_rd, dmem_addr, dmem_be and dmem_wdata are 0.
- FSM states: IDLE, REQ, WAIT_R. All outputs are registered. stall = (state != IDLE), which is combinational from state only.
- IDLE with ex_valid=0: wb_valid=0 next cycle.
- IDLE with ex_valid=1 and no memory op: next cycle wb_valid=1, wb_result=ex_alu_result, wb_rd, wb_reg_write=ex_reg_write. Latency is 1 and there is no stall.
- IDLE with a memory op, misaligned: misaligned means H with addr[0]=1, or W with addr[1:0]!=0. Next cycle wb_valid=1, wb_misaligned=1, wb_reg_write=0. No dmem request; the FSM stays in IDLE.
- IDLE with a memory op, aligned: latch rd, funct3, addr[1:0] and reg_write. Next cycle the FSM is in REG with dmem_req=1, dmem_we=ex_mem_write, and dmem_addr/be/wdata valid.
- Store byte lanes:
  - SB: be=0001<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: be=0011<<addr[1:0], wdata={2{data[15:0]}}.
  - SW: be=1111, wdata=data.
- Load byte enables: same be encoding, for information only.
- REQ: dmem_req and all request fields are held stable until dmem_ready=1.
  - Store accepted: dmem_req=0 and state IDLE next cycle; wb_valid=1, wb_reg_write=0.
  - Load accepted: dmem_req=0 and state WAIT_R next cycle.
- WAIT_R: the FSM waits for dmem_rvalid. rvalid is ignored in IDLE and REQ; memory never returns rvalid in the acceptance cycle. On rvalid, the next cycle gives state IDLE and wb_valid=1.
  - wb_result = selected lane extended: B/H sign-extended, BU/HU zero-extended, W unchanged.
  - Lane select uses the latched addr[1:0].
- stall deasserts in the same cycle the FSM re-enters IDLE, so EX may present the next instruction in that cycle.
- ex_* inputs are sampled only in IDLE. EX changes while stalled are ignored.
- ex_mem_read & ex_mem_write both set is illegal: treat as a load. The bench must not drive it.
- Undefined funct3 on a memory op: treated as W.
- Reset mid-transaction: immediately returns to IDLE with all outputs cleared. The outstanding memory response is dropped (memory is reset by the same rst_n).
- wb_valid is exactly one cycle per accepted instruction.

Decomposition:
- Shared package holds: FSM state encoding; funct3 constants (F3_B/H/W/BU/HU); byte-enable width constant (XLEN/8).
- One sub-module, mem_align: purely combinational.
  - Store path: addr[1:0] + funct3 + store data -> be/wdata.
  - Load path: addr[1:0] + funct3 + rdata -> extended result.
  - Also produces the misaligned flag.
- The FSM and the pipeline registers stay in mem_stage.

Test Plan:
- ALU pass-through: ex_valid, no mem op, alu_result=0x0000_00A5, rd=7, reg_write=1 -> next cycle wb_valid=1, wb_result=0xA5, wb_rd=7, stall never set.
- SB with backpressure: addr=0x1003, data=0x1234_56EF, dmem_ready low for 3 cycles -> dmem_addr=0x1000, be=1000, wdata=0xEFEF_EFEF, all held stable for 3 cycles, then wb_valid with wb_reg_write=0; stall high for exactly the REQ cycles.
- LB sign-extend: addr=0x2002, rdata=0x0080_0000, rvalid 2 cycles after accept -> wb_result=0xFFFF_FF80. Same access as LBU -> wb_result=0x0000_0080.
- LH/LW: LH at 0x2002 with rdata=0x8001_1234 -> wb_result=0xFFFF_8001. LW at 0x2000 -> wb_result=0x8001_1234.
- Misaligned LW: addr=0x3001 -> dmem_req never asserts, next cycle wb_valid=1, wb_misaligned=1, wb_reg_write=0.
- Reset in WAIT_R: rst_n low during a pending load -> stall, dmem_req and wb_valid go 0 immediately. After release, a pass-through instruction completes in 1 cycle.
